// File: rtl/imem_loader.sv
// imem_loader: streams a framed program image byte-by-byte, assembles 32-bit
// little-endian words and writes them into instruction memory. The core is
// held in reset until a load completes with a matching XOR checksum.
//
// Frame: LEN[7:0], LEN[15:8], LEN*4 payload bytes, XOR-of-payload checksum.
//
// Ports:
//   clk           system clock, posedge
//   reset         synchronous active-low reset
//   start         one-cycle pulse to begin a load (IDLE/DONE/ERROR only)
//   s_valid       byte-stream valid
//   s_data        byte-stream data
//   s_ready       byte-stream ready
//   imem_we       instruction-memory write strobe, one cycle per word
//   imem_addr     word address of the write
//   imem_wdata    instruction word to write
//   core_hold     1 = processor held in reset
//   busy          load in progress
//   done          last load succeeded
//   error         last load failed
//   words_written number of words written in the current/last load
module imem_loader #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   output logic                  s_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_written
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_e;

   state_e                state_q, state_d;
   logic [15:0]           len_q;
   logic [ADDR_WIDTH:0]   word_idx_q;
   logic [1:0]            byte_idx_q;
   logic [23:0]           word_q;
   logic [7:0]            csum_q;
   logic                  s_ready_q;
   logic                  imem_we_q;
   logic [ADDR_WIDTH-1:0] imem_addr_q;
   logic [31:0]           imem_wdata_q;
   logic                  core_hold_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  error_q;
   logic [ADDR_WIDTH:0]   words_written_q;

   logic                  hs_c;
   logic [15:0]           len_full_c;

   assign hs_c       = s_valid & s_ready_q;
   // full length as seen during the LEN_HI handshake
   assign len_full_c = {s_data, len_q[7:0]};

   // Next-state decision
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) state_d = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (hs_c) state_d = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (hs_c) begin
               if (len_full_c == 16'd0)              state_d = S_CHECK;
               else if (32'(len_full_c) > DEPTH)     state_d = S_ERROR;
               else                                  state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (hs_c && (byte_idx_q == 2'd3)) state_d = S_WRITE;
         end
         S_WRITE: begin
            if ((32'(word_idx_q) + 32'd1) == 32'(len_q)) state_d = S_CHECK;
            else                                         state_d = S_DATA;
         end
         S_CHECK: begin
            if (hs_c) state_d = (s_data == csum_q) ? S_DONE : S_ERROR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         len_q           <= '0;
         word_idx_q      <= '0;
         byte_idx_q      <= '0;
         word_q          <= '0;
         csum_q          <= '0;
         s_ready_q       <= 1'b0;
         imem_we_q       <= 1'b0;
         imem_addr_q     <= '0;
         imem_wdata_q    <= '0;
         core_hold_q     <= 1'b1;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
         words_written_q <= '0;
      end else begin
         state_q   <= state_d;
         s_ready_q <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                      (state_d == S_DATA)   || (state_d == S_CHECK);
         busy_q    <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                      (state_d == S_DATA)   || (state_d == S_WRITE)  ||
                      (state_d == S_CHECK);
         imem_we_q <= (state_d == S_WRITE);

         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  word_idx_q      <= '0;
                  byte_idx_q      <= '0;
                  csum_q          <= '0;
                  words_written_q <= '0;
                  done_q          <= 1'b0;
                  error_q         <= 1'b0;
                  core_hold_q     <= 1'b1;
               end
            end
            S_LEN_LO: begin
               if (hs_c) len_q[7:0] <= s_data;
            end
            S_LEN_HI: begin
               if (hs_c) len_q[15:8] <= s_data;
            end
            S_DATA: begin
               if (hs_c) begin
                  csum_q     <= csum_q ^ s_data;
                  byte_idx_q <= byte_idx_q + 2'd1;
                  case (byte_idx_q)
                     2'd0: word_q[7:0]   <= s_data;
                     2'd1: word_q[15:8]  <= s_data;
                     2'd2: word_q[23:16] <= s_data;
                     default: begin
                        // last byte: address and word are frozen for the WRITE cycle
                        imem_addr_q  <= word_idx_q[ADDR_WIDTH-1:0];
                        imem_wdata_q <= {s_data, word_q};
                     end
                  endcase
               end
            end
            S_WRITE: begin
               word_idx_q      <= word_idx_q + 1'b1;
               words_written_q <= words_written_q + 1'b1;
            end
            default: ;
         endcase

         if (state_d == S_DONE) begin
            done_q      <= 1'b1;
            core_hold_q <= 1'b0;
         end
         if (state_d == S_ERROR) begin
            error_q     <= 1'b1;
            core_hold_q <= 1'b1;
         end
      end
   end

   assign s_ready       = s_ready_q;
   assign imem_we       = imem_we_q;
   assign imem_addr     = imem_addr_q;
   assign imem_wdata    = imem_wdata_q;
   assign core_hold     = core_hold_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign words_written = words_written_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed and randomized frames checked against
// a frame-level reference model (expected writes and pass/fail result).
module tb_imem_loader;

   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 256;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          s_valid;
   logic [7:0]    s_data;
   logic          s_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_hold;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW:0]   words_written;

   always #5 clk = ~clk;

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_ready      (s_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_hold    (core_hold),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_written(words_written)
   );

   int          errors = 0;
   int          checks = 0;
   logic [31:0] pay_q[$];
   int          wa_q[$];
   logic [31:0] wd_q[$];
   int          rdy_viol  = 0;
   int          busy_viol = 0;
   bit          chk_busy  = 1'b0;

   // Observe writes and protocol properties away from the active edge
   always @(negedge clk) begin
      if (imem_we) begin
         wa_q.push_back(int'(imem_addr));
         wd_q.push_back(imem_wdata);
         if (s_ready) rdy_viol++;
      end
      if (chk_busy && !busy) busy_viol++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] xor_of(input int n);
      logic [7:0] x = 8'h00;
      for (int i = 0; i < n; i++)
         x ^= pay_q[i][7:0] ^ pay_q[i][15:8] ^ pay_q[i][23:16] ^ pay_q[i][31:24];
      return x;
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start   = 1'b1;
      s_valid = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Offer one byte after 'gap' idle cycles; returns at the handshake edge
   task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
      int n = 0;
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         s_valid = 1'b0;
         s_data  = 8'($urandom);
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk({tag, ":ready_timeout"}, 64'(n), 64'(0));
      @(posedge clk);
   endtask

   task automatic run_frame(input int len, input logic [7:0] cks, input int gap,
                            input int glitch_at, input string tag);
      int base, rv0, bv0, nwr, n, nobs;
      bit ok;
      base = wa_q.size();
      rv0  = rdy_viol;
      bv0  = busy_viol;
      nwr  = (len <= DEPTH) ? len : 0;
      ok   = (len <= DEPTH) && (xor_of(nwr) == cks);

      pulse_start();
      chk_busy = 1'b1;
      send_byte(8'(len), gap, tag);
      send_byte(8'(len >> 8), gap, tag);
      if (len > DEPTH) begin
         chk_busy = 1'b0;
         @(negedge clk);
         chk({tag, ":ovf_error_next"}, 64'(error), 64'(1));
         chk({tag, ":ovf_s_ready"}, 64'(s_ready), 64'(0));
      end else begin
         for (int i = 0; i < len; i++) begin
            for (int k = 0; k < 4; k++) begin
               if (i * 4 + k == glitch_at) begin
                  @(negedge clk);
                  s_valid = 1'b0;
                  start   = 1'b1;
                  @(posedge clk);
                  #1 start = 1'b0;
               end
               send_byte(pay_q[i][8*k +: 8], gap, tag);
            end
         end
         send_byte(cks, gap, tag);
         chk_busy = 1'b0;
      end

      n = 0;
      @(negedge clk);
      s_valid = 1'b0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ":busy"},      64'(busy),      64'(0));
      chk({tag, ":done"},      64'(done),      64'(ok));
      chk({tag, ":error"},     64'(error),     64'(!ok));
      chk({tag, ":core_hold"}, 64'(core_hold), 64'(!ok));
      chk({tag, ":s_ready"},   64'(s_ready),   64'(0));
      chk({tag, ":words_written"}, 64'(words_written), 64'(nwr));
      nobs = wa_q.size() - base;
      chk({tag, ":num_writes"}, 64'(nobs), 64'(nwr));
      for (int i = 0; i < nwr && i < nobs; i++) begin
         chk($sformatf("%s:addr%0d", tag, i), 64'(wa_q[base + i]), 64'(i));
         chk($sformatf("%s:data%0d", tag, i), 64'(wd_q[base + i]), 64'(pay_q[i]));
      end
      chk({tag, ":ready_in_write"}, 64'(rdy_viol - rv0), 64'(0));
      chk({tag, ":busy_hole"}, 64'(busy_viol - bv0), 64'(0));
   endtask

   task automatic load_scenario1();
      pay_q.delete();
      pay_q.push_back(32'h00a00513);
      pay_q.push_back(32'h00b00593);
   endtask

   initial begin
      int base, len;
      logic [7:0] cks;

      reset   = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst:s_ready",   64'(s_ready),       64'(0));
      chk("rst:imem_we",   64'(imem_we),       64'(0));
      chk("rst:imem_addr", 64'(imem_addr),     64'(0));
      chk("rst:wdata",     64'(imem_wdata),    64'(0));
      chk("rst:busy",      64'(busy),          64'(0));
      chk("rst:done",      64'(done),          64'(0));
      chk("rst:error",     64'(error),         64'(0));
      chk("rst:ww",        64'(words_written), 64'(0));
      chk("rst:core_hold", 64'(core_hold),     64'(1));
      reset = 1'b1;

      // Two-word load, then bad checksum
      load_scenario1();
      run_frame(2, 8'h90, 0, -1, "t1");
      run_frame(2, 8'h91, 0, -1, "t2");

      // Zero length: good and bad checksum
      run_frame(0, 8'h00, 0, -1, "t3a");
      run_frame(0, 8'h01, 0, -1, "t3b");

      // Oversize and full-memory boundary
      run_frame(257, 8'h00, 0, -1, "t4ovf");
      pay_q.delete();
      for (int i = 0; i < 256; i++) pay_q.push_back($urandom);
      run_frame(256, xor_of(256), 0, -1, "t4full");

      // Backpressure: valid every other cycle
      load_scenario1();
      run_frame(2, 8'h90, 1, -1, "t5");

      // Reset in the middle of the payload
      base = wa_q.size();
      pulse_start();
      send_byte(8'h02, 0, "t6r");
      send_byte(8'h00, 0, "t6r");
      send_byte(8'h13, 0, "t6r");
      send_byte(8'h05, 0, "t6r");
      @(negedge clk);
      s_valid = 1'b0;
      reset   = 1'b0;
      @(negedge clk);
      reset   = 1'b1;
      chk("t6r:busy",      64'(busy),      64'(0));
      chk("t6r:core_hold", 64'(core_hold), 64'(1));
      chk("t6r:s_ready",   64'(s_ready),   64'(0));
      chk("t6r:ww",        64'(words_written), 64'(0));
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = 8'($urandom);
      end
      @(negedge clk);
      s_valid = 1'b0;
      chk("t6r:no_write", 64'(wa_q.size() - base), 64'(0));
      chk("t6r:idle_busy", 64'(busy), 64'(0));
      run_frame(2, 8'h90, 0, -1, "t6clean");
      run_frame(2, 8'h90, 0, 5, "t6start_in_data");

      // Randomized frames
      for (int r = 0; r < 8; r++) begin
         len = int'($urandom_range(1, 6));
         pay_q.delete();
         for (int i = 0; i < len; i++) pay_q.push_back($urandom);
         cks = xor_of(len);
         if ($urandom_range(0, 3) == 0) cks = cks ^ 8'(1 << $urandom_range(0, 7));
         run_frame(len, cks, int'($urandom_range(0, 2)), -1, $sformatf("rnd%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-fetch path: streams a program image byte-by-byte, assembles 32-bit little-endian instruction words and writes them into instruction memory.
- Holds the pipelined core in reset (core_hold) until a load completes with a valid checksum.
- Replaces preloading of instruction memory from file for bring-up and regression.

Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory; capacity is 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset; 0 at a posedge = reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE, ERROR.
- s_valid  input  1  byte-stream valid.
- s_data  input  8  byte-stream data.
- s_ready  output  1  byte-stream ready; a byte transfers on a posedge with s_valid & s_ready.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  word address of the write.
- imem_wdata  output  32  instruction word to write.
- core_hold  output  1  1 = processor held in reset.
- busy  output  1  load in progress (LEN_LO through CHECK).
- done  output  1  last load succeeded.
- error  output  1  last load failed.
- words_written  output  ADDR_WIDTH+1  count of imem_we pulses in the current or last load.

Behaviour:
- Reset (reset==0 at a posedge): state=IDLE. s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, words_written=0, core_hold=1. Instruction memory contents are not cleared.
- Frame format: LEN[7:0], LEN[15:8], then LEN*4 payload bytes, then one checksum byte equal to the XOR of all payload bytes.
- Within each word, bytes arrive least-significant first: byte k lands in bits [8k+7:8k].
- IDLE: s_ready=0.
  - start=1 -> LEN_LO.
  - On entry to LEN_LO, clear word_idx, byte_idx, checksum, words_written, done and error; set core_hold=1.
- LEN_LO: s_ready=1. On handshake, latch len[7:0] -> LEN_HI.
- LEN_HI: s_ready=1. On handshake, latch len[15:8]; next state is decided in the same cycle on the full 16-bit length:
  - len==0 -> CHECK.
  - len > 2**ADDR_WIDTH -> ERROR. No payload is consumed.
  - otherwise -> DATA.
- DATA: s_ready=1.
  - Each handshake places the byte at byte_idx, XORs it into checksum and increments byte_idx.
  - The handshake with byte_idx==3 -> WRITE and wraps byte_idx to 0.
- WRITE: s_ready=0; imem_we=1 for exactly this cycle, imem_addr=word_idx, imem_wdata=assembled word.
  - words_written and word_idx increment at the end of the cycle.
  - word_idx+1==len -> CHECK; else -> DATA.
  - Throughput: 5 cycles per word with continuous s_valid.
- CHECK: s_ready=1. On handshake, byte==checksum -> DONE; else -> ERROR.
- DONE: done=1, core_hold=0, s_ready=0. Held until start.
- ERROR: error=1, core_hold=1, s_ready=0. Held until start. Words already written stay in memory.
- busy=1 exactly in LEN_LO, LEN_HI, DATA, WRITE, CHECK.
- start while busy: ignored, no state change.
- s_valid=0 stalls any state with no side effects. s_data is ignored when there is no handshake.
- reset mid-load: immediate return to IDLE with core_hold=1 and no further imem_we. The partial frame is discarded and the next frame must begin with a fresh start.
- imem_addr and imem_wdata are don't-care when imem_we=0 but must not glitch during WRITE.
- The len == 2**ADDR_WIDTH case is legal and fills memory fully; word_idx needs ADDR_WIDTH+1 bits.

Test Plan:
1. Two-word load.
   - Stimulus: start, then 02 00 | 13 05 a0 00 | 93 05 b0 00 | 90.
   - Required: imem_we pulses at addr0=0x00a00513 and addr1=0x00b00593; then done=1, core_hold=0, error=0, words_written=2.
2. Bad checksum.
   - Stimulus: same frame with checksum byte 91.
   - Required: both writes occur, error=1, done=0, core_hold=1, words_written=2.
3. Zero length.
   - Stimulus: start, 00 00 00.
   - Required: no imem_we; done=1, core_hold=0.
   - Follow-up: start, 00 00 01 gives error=1.
4. Oversize length.
   - Stimulus: ADDR_WIDTH=8, start, 01 01 (len=257).
   - Required: error=1 in the cycle after the LEN_HI handshake, s_ready=0, no imem_we.
   - Boundary check: 00 01 (len=256) is accepted and writes addr 0..255.
5. Backpressure.
   - Stimulus: scenario 1 with s_valid asserted every other cycle and random s_data while s_valid=0.
   - Required: identical writes and done result; s_ready=0 in every WRITE cycle; busy=1 throughout.
6. Reset and start races.
   - Stimulus: reset=0 for one cycle after 2 payload bytes.
   - Required: IDLE, core_hold=1, no imem_we. A subsequent clean scenario-1 load succeeds.
   - Also: start pulsed during DATA has no effect.
